// File: rtl/relu_maxpool2d.sv
// rtl/relu_maxpool2d.sv - streaming ReLU + 2x2/stride-2 max-pool stage (optional clamp: RELU_EN)
module relu_maxpool2d #(
  parameter int N = 24,
  parameter int Q = 13,
  parameter int H = 4,
  parameter int W = 41
) (
  input  logic         clk,
  input  logic         global_rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_last
);

  // Q only describes the fixed-point format; nothing here depends on it.
  localparam int unused_q_bits = Q;

  localparam int CW       = $clog2(W);
  localparam int RW       = $clog2(H);
  localparam int LBD      = W / 2;
  localparam int LIW      = (LBD > 1) ? $clog2(LBD) : 1;
  localparam int LAST_ROW = 2 * (H / 2) - 1;
  localparam int LAST_COL = 2 * (W / 2) - 1;

  logic [CW-1:0]       col;
  logic [RW-1:0]       row;
  logic signed [N-1:0] hreg;
  logic signed [N-1:0] lbuf [LBD];

  logic                xfer;
  logic                col_wrap;
  logic                row_wrap;
  logic                col_paired;
  logic                row_paired;
  logic [LIW-1:0]      lidx;
  logic signed [N-1:0] x_t;
  logic signed [N-1:0] hm;
  logic signed [N-1:0] lb_rd;
  logic signed [N-1:0] vm;

  // The stage only stalls when a pooled result is still waiting for the consumer.
  assign in_ready   = !out_valid || out_ready;
  assign xfer       = in_valid && in_ready;
  assign col_wrap   = (int'(col) == W - 1);
  assign row_wrap   = (int'(row) == H - 1);
  // A trailing odd column / odd row has no partner and is dropped.
  assign col_paired = (int'(col) <= LAST_COL);
  assign row_paired = (int'(row) <= LAST_ROW);
  assign lidx       = LIW'(col >> 1);
  assign lb_rd      = lbuf[lidx];

  // Pixel transform, then horizontal and vertical pair maxima.
  always_comb begin
    x_t = $signed(in_data);
`ifdef RELU_EN
    if (x_t < 0) begin
      x_t = '0;
    end
`endif
    hm = (hreg > x_t) ? hreg : x_t;
    vm = (hm > lb_rd) ? hm : lb_rd;
  end

  // Raster counters, horizontal holding register and the single-entry output stage.
  always_ff @(posedge clk) begin
    if (global_rst) begin
      col       <= '0;
      row       <= '0;
      hreg      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (xfer) begin
        if (col_wrap) begin
          col <= '0;
          row <= row_wrap ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end

        if (!col[0]) begin
          if (col_paired) begin
            hreg <= x_t;
          end
        end else if (row[0]) begin
          out_valid <= 1'b1;
          out_data  <= vm;
          out_last  <= (int'(row) == LAST_ROW) && (int'(col) == LAST_COL);
        end
      end
    end
  end

  // Half-width line buffer of even-row pair maxima; always written before it is read.
  always_ff @(posedge clk) begin
    if (!global_rst && xfer && col[0] && !row[0] && row_paired) begin
      lbuf[lidx] <= hm;
    end
  end

endmodule

// File: tb/tb_relu_maxpool2d.sv
// tb/tb_relu_maxpool2d.sv - self-checking bench for relu_maxpool2d (4x4 and 5x5 instances)
module tb_relu_maxpool2d;

  localparam int N = 24;

  logic         clk = 1'b0;
  logic         global_rst = 1'b0;
  logic         in_valid = 1'b0;
  logic [N-1:0] in_data = '0;
  logic         out_ready = 1'b0;

  logic         a_in_ready, a_out_valid, a_out_last;
  logic [N-1:0] a_out_data;
  logic         b_in_ready, b_out_valid, b_out_last;
  logic [N-1:0] b_out_data;

  bit           sel = 1'b0;
  logic         cur_in_ready, cur_out_valid, cur_out_last;
  logic [N-1:0] cur_out_data;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;

  logic [N-1:0] got_data [$];
  bit           got_last [$];
  int           got_cyc  [$];
  logic [N-1:0] exp_data [$];
  bit           exp_last [$];
  int           exp_idx  [$];
  int           acc_cyc  [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  relu_maxpool2d #(.N(N), .Q(13), .H(4), .W(4)) dut_a (
    .clk(clk), .global_rst(global_rst),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data), .out_last(a_out_last)
  );

  relu_maxpool2d #(.N(N), .Q(13), .H(5), .W(5)) dut_b (
    .clk(clk), .global_rst(global_rst),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data), .out_last(b_out_last)
  );

  assign cur_in_ready  = sel ? b_in_ready  : a_in_ready;
  assign cur_out_valid = sel ? b_out_valid : a_out_valid;
  assign cur_out_data  = sel ? b_out_data  : a_out_data;
  assign cur_out_last  = sel ? b_out_last  : a_out_last;

  // Record every output transfer of the selected instance, with the cycle it was visible.
  always @(negedge clk) begin
    #2;
    if (cur_out_valid && out_ready) begin
      got_data.push_back(cur_out_data);
      got_last.push_back(cur_out_last);
      got_cyc.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [N-1:0] xf(input logic [N-1:0] v);
`ifdef RELU_EN
    return v[N-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [N-1:0] smax(input logic [N-1:0] x, input logic [N-1:0] y);
    return ($signed(x) > $signed(y)) ? x : y;
  endfunction

  // Reference: for each 2x2 window of one frame, the max of the transformed pixels.
  function automatic void add_expected(input int h, input int w, input logic [N-1:0] pix [$], input int base);
    for (int r = 0; r < h / 2; r++) begin
      for (int c = 0; c < w / 2; c++) begin
        logic [N-1:0] m;
        m = smax(smax(xf(pix[2*r*w + 2*c]), xf(pix[2*r*w + 2*c + 1])),
                 smax(xf(pix[(2*r+1)*w + 2*c]), xf(pix[(2*r+1)*w + 2*c + 1])));
        exp_data.push_back(m);
        exp_last.push_back((r == h / 2 - 1) && (c == w / 2 - 1));
        exp_idx.push_back(base + (2*r+1)*w + 2*c + 1);
      end
    end
  endfunction

  task automatic clear_all();
    got_data.delete(); got_last.delete(); got_cyc.delete();
    exp_data.delete(); exp_last.delete(); exp_idx.delete();
    acc_cyc.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    global_rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    global_rst = 1'b0;
    clear_all();
  endtask

  task automatic send_pixel(input logic [N-1:0] d, output int acc);
    int budget;
    @(negedge clk);
    in_valid = 1'b1;
    in_data = d;
    #1;
    budget = 0;
    while (!cur_in_ready && budget < 300) begin
      @(negedge clk);
      #1;
      budget++;
    end
    if (!cur_in_ready) begin
      n_checks++;
      $display("FAIL in_ready_timeout: in_ready=%0b after %0d cycles, required 1", cur_in_ready, budget);
    end
    acc = cyc;
    @(posedge clk);
  endtask

  task automatic send_frame(input logic [N-1:0] pix [$], input int gap_max);
    int a;
    int g;
    foreach (pix[i]) begin
      send_pixel(pix[i], a);
      acc_cyc.push_back(a);
      g = (gap_max > 0) ? $urandom_range(gap_max, 0) : 0;
      if (g > 0) begin
        @(negedge clk);
        in_valid = 1'b0;
        repeat (g - 1) @(negedge clk);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_outputs(input int n);
    int budget;
    budget = 0;
    while (got_data.size() < n && budget < 400) begin
      @(negedge clk);
      budget++;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    sel = 1'b0;
    out_ready = 1'b0;
    do_reset();
    #2;
    n_checks++; if (a_out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b, required 0", a_out_valid); else n_pass++;
    n_checks++; if (a_out_data !== '0) $display("FAIL reset_out_data: got %0h, required 0", a_out_data); else n_pass++;
    n_checks++; if (a_out_last !== 1'b0) $display("FAIL reset_out_last: got %0b, required 0", a_out_last); else n_pass++;
    n_checks++; if (a_in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b, required 1", a_in_ready); else n_pass++;
    n_checks++; if (b_out_valid !== 1'b0) $display("FAIL reset_out_valid_5x5: got %0b, required 0", b_out_valid); else n_pass++;
  endtask

  task automatic test_basic();
    logic [N-1:0] pix [$];
    sel = 1'b0;
    out_ready = 1'b1;
    do_reset();
    for (int i = 1; i <= 16; i++) pix.push_back(N'(i));
    add_expected(4, 4, pix, 0);
    send_frame(pix, 0);
    wait_outputs(4);
    n_checks++; if (got_data.size() !== 4) $display("FAIL basic_count: got %0d outputs, required 4", got_data.size()); else n_pass++;
    for (int i = 0; i < 4 && i < got_data.size(); i++) begin
      n_checks++; if (got_data[i] !== exp_data[i]) $display("FAIL basic_data[%0d]: got %0d, required %0d", i, $signed(got_data[i]), $signed(exp_data[i])); else n_pass++;
      n_checks++; if (got_last[i] !== exp_last[i]) $display("FAIL basic_last[%0d]: got %0b, required %0b", i, got_last[i], exp_last[i]); else n_pass++;
      n_checks++; if (got_cyc[i] !== acc_cyc[exp_idx[i]] + 1) $display("FAIL basic_latency[%0d]: visible at cycle %0d, required %0d", i, got_cyc[i], acc_cyc[exp_idx[i]] + 1); else n_pass++;
    end
  endtask

  task automatic test_relu();
    logic [N-1:0] pix [$];
    sel = 1'b0;
    out_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 16; i++) pix.push_back(24'hFFFFFB);
    add_expected(4, 4, pix, 0);
    send_frame(pix, 0);
    wait_outputs(4);
    n_checks++; if (got_data.size() !== 4) $display("FAIL relu_count: got %0d outputs, required 4", got_data.size()); else n_pass++;
    for (int i = 0; i < 4 && i < got_data.size(); i++) begin
      n_checks++; if (got_data[i] !== exp_data[i]) $display("FAIL relu_data[%0d]: got %0d, required %0d", i, $signed(got_data[i]), $signed(exp_data[i])); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] pix [$];
    sel = 1'b0;
    out_ready = 1'b0;
    do_reset();
    for (int i = 1; i <= 16; i++) pix.push_back(N'(i));
    add_expected(4, 4, pix, 0);
    fork
      send_frame(pix, 0);
      begin
        int budget;
        budget = 0;
        @(negedge clk);
        #2;
        while (!a_out_valid && budget < 300) begin
          @(negedge clk);
          #2;
          budget++;
        end
        for (int k = 0; k < 3; k++) begin
          n_checks++; if (a_out_valid !== 1'b1) $display("FAIL stall_valid[%0d]: got %0b, required 1", k, a_out_valid); else n_pass++;
          n_checks++; if (a_out_data !== 24'd6) $display("FAIL stall_data[%0d]: got %0d, required 6", k, a_out_data); else n_pass++;
          n_checks++; if (a_in_ready !== 1'b0) $display("FAIL stall_in_ready[%0d]: got %0b, required 0", k, a_in_ready); else n_pass++;
          @(negedge clk);
          if (k < 2) #2;
        end
        out_ready = 1'b1;
      end
    join
    wait_outputs(4);
    n_checks++; if (got_data.size() !== 4) $display("FAIL bp_count: got %0d outputs, required 4", got_data.size()); else n_pass++;
    for (int i = 0; i < 4 && i < got_data.size(); i++) begin
      n_checks++; if (got_data[i] !== exp_data[i]) $display("FAIL bp_data[%0d]: got %0d, required %0d", i, $signed(got_data[i]), $signed(exp_data[i])); else n_pass++;
      n_checks++; if (got_last[i] !== exp_last[i]) $display("FAIL bp_last[%0d]: got %0b, required %0b", i, got_last[i], exp_last[i]); else n_pass++;
    end
  endtask

  task automatic test_odd_dims();
    logic [N-1:0] pix [$];
    logic [N-1:0] pix2 [$];
    sel = 1'b1;
    out_ready = 1'b1;
    do_reset();
    for (int i = 1; i <= 25; i++) pix.push_back(N'(i));
    add_expected(5, 5, pix, 0);
    send_frame(pix, 0);
    wait_outputs(4);
    n_checks++; if (got_data.size() !== 4) $display("FAIL odd_count: got %0d outputs, required 4", got_data.size()); else n_pass++;
    for (int i = 0; i < 4 && i < got_data.size(); i++) begin
      n_checks++; if (got_data[i] !== exp_data[i]) $display("FAIL odd_data[%0d]: got %0d, required %0d", i, $signed(got_data[i]), $signed(exp_data[i])); else n_pass++;
      n_checks++; if (got_last[i] !== exp_last[i]) $display("FAIL odd_last[%0d]: got %0b, required %0b", i, got_last[i], exp_last[i]); else n_pass++;
    end
    clear_all();
    for (int i = 0; i < 25; i++) pix2.push_back(N'($urandom));
    add_expected(5, 5, pix2, 0);
    send_frame(pix2, 1);
    wait_outputs(4);
    n_checks++; if (got_data.size() !== 4) $display("FAIL odd2_count: got %0d outputs, required 4", got_data.size()); else n_pass++;
    for (int i = 0; i < 4 && i < got_data.size(); i++) begin
      n_checks++; if (got_data[i] !== exp_data[i]) $display("FAIL odd2_data[%0d]: got %0d, required %0d", i, $signed(got_data[i]), $signed(exp_data[i])); else n_pass++;
    end
    sel = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] pix [$];
    int a;
    sel = 1'b0;
    out_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 7; i++) send_pixel(N'($urandom), a);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    send_pixel(N'($urandom), a);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    n_checks++; if (a_out_valid !== 1'b1) $display("FAIL midrst_pending: got %0b, required 1", a_out_valid); else n_pass++;
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #2;
      n_checks++; if (a_out_valid !== 1'b0) $display("FAIL midrst_idle_valid[%0d]: got %0b, required 0", k, a_out_valid); else n_pass++;
      @(negedge clk);
    end
    for (int i = 1; i <= 16; i++) pix.push_back(N'(i));
    add_expected(4, 4, pix, 0);
    send_frame(pix, 0);
    wait_outputs(4);
    n_checks++; if (got_data.size() !== 4) $display("FAIL midrst_count: got %0d outputs, required 4", got_data.size()); else n_pass++;
    for (int i = 0; i < 4 && i < got_data.size(); i++) begin
      n_checks++; if (got_data[i] !== exp_data[i]) $display("FAIL midrst_data[%0d]: got %0d, required %0d", i, $signed(got_data[i]), $signed(exp_data[i])); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] pix [$];
    bit done;
    sel = 1'b0;
    out_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 32; i++) pix.push_back(N'($urandom));
    add_expected(4, 4, pix[0:15], 0);
    add_expected(4, 4, pix[16:31], 16);
    done = 1'b0;
    fork
      begin
        send_frame(pix, 2);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          out_ready = 1'($urandom_range(1, 0));
        end
      end
    join
    @(negedge clk);
    out_ready = 1'b1;
    wait_outputs(8);
    n_checks++; if (got_data.size() !== 8) $display("FAIL b2b_count: got %0d outputs, required 8", got_data.size()); else n_pass++;
    for (int i = 0; i < 8 && i < got_data.size(); i++) begin
      n_checks++; if (got_data[i] !== exp_data[i]) $display("FAIL b2b_data[%0d]: got %0d, required %0d", i, $signed(got_data[i]), $signed(exp_data[i])); else n_pass++;
      n_checks++; if (got_last[i] !== exp_last[i]) $display("FAIL b2b_last[%0d]: got %0b, required %0b", i, got_last[i], exp_last[i]); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_relu();
    test_backpressure();
    test_odd_dims();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/relu_maxpool2d.md
# relu_maxpool2d

Streaming ReLU + 2×2/stride-2 max-pool stage that sits directly downstream of `Conv2d` in the CRNN feature extractor. It consumes one output channel's map as a raster-order stream of signed Q-format pixels, one pixel per handshake. It emits the pooled map in raster order. Row-pair maxima are held in an internal half-width line buffer, so no full frame is stored.

## Interface
Parameters:
- `N`, 24: pixel width, signed fixed point, two's complement.
- `Q`, 13: fractional bits. Carried through only; no arithmetic depends on it.
- `H`, 4: input map height in pixels (≥2).
- `W`, 41: input map width in pixels (≥2).

Ports:
- `clk`, in, 1: the single clock; everything is rising-edge.
- `global_rst`, in, 1: reset, synchronous and active-high.
- `in_valid`, in, 1: `in_data` is valid.
- `in_ready`, out, 1: the stage can accept a pixel.
- `in_data`, in, N: input pixel, signed.
- `out_valid`, out, 1: `out_data` is valid.
- `out_ready`, in, 1: the consumer accepts the output.
- `out_data`, out, N: pooled pixel, signed.
- `out_last`, out, 1: marks the final pooled pixel of a frame.

## Operation
- An input transfer occurs when `in_valid && in_ready`. An output transfer occurs when `out_valid && out_ready`.
- Counters `col` (0..W-1) and `row` (0..H-1) advance on each input transfer.
  - `col` wraps to 0 after W-1 and increments `row`.
  - `row` wraps to 0 after H-1, which ends the frame.
- Pixel transform `x'`:
  - With `RELU_EN` defined: `x' = (x<0) ? 0 : x`.
  - Without it: `x' = x`.
- All compares are signed N-bit. There is no width growth and no saturation.
- Even `col`: latch `x'` into holding register `hreg`.
- Odd `col`: compute `hm = max(hreg, x')`.
  - Even `row`: write `hm` into `lbuf[col>>1]`. `lbuf` has `W/2` entries (floor).
  - Odd `row`: load `max(hm, lbuf[col>>1])` into the output register and set `out_valid`.
- Odd W: the last column is accepted and discarded, with no buffer write.
- Odd H: the last row is accepted and discarded, with no output.
- Output map size is `(H/2) × (W/2)`, floor division.
- `out_last` is 1 for the output produced at `row = 2*(H/2)-1` and `col = 2*(W/2)-1`, and 0 for every other output.
- The output stage is a single register:
  - It holds `out_data` and `out_last` stable while `out_valid && !out_ready`.
  - `out_valid` clears on an output transfer unless a new result is loaded in the same cycle.

## Timing
- Throughput is one input pixel per clock when `out_ready` is held high.
- Latency: a pooled result is visible on `out_*` in the cycle after the input transfer that completes its 2×2 window.
- `in_ready = !out_valid || out_ready`, combinational from the output register and `out_ready`.
  - This stalls only when an unconsumed output exists.
  - A simultaneous output transfer and new result load is legal and yields back-to-back `out_valid`.
- `in_data` is sampled only on an input transfer. `in_valid` low freezes all counters and registers.
- Reset values:
  - `out_valid=0`, `out_data=0`, `out_last=0`.
  - `row=0`, `col=0`, `hreg=0`.
  - `lbuf` is not reset; it is always written before it is read.
- `global_rst` mid-frame discards the partial frame and any pending output. The next accepted pixel is treated as (row 0, col 0).
- `global_rst` has priority over any simultaneous transfer.

## Configuration
- `RELU_EN` defined: negative pixels are clamped to 0 before pooling, so every output is ≥ 0.
- `RELU_EN` not defined: pure signed max-pool, and negative outputs pass through unchanged.

## Test plan
- **Basic 4×4 pooling:** `RELU_EN` defined, H=4, W=4, inputs 1..16 raster order, `out_ready=1` → outputs 6, 8, 14, 16, in order. `out_last` is 1 only with 16. Each output appears one cycle after inputs 6, 8, 14, 16 are accepted.
- **ReLU clamp vs. pass-through:** H=4, W=4, all inputs -5 (0xFFFFFB) → four outputs of 0 with `RELU_EN`, and four outputs of -5 without it.
- **Backpressure:** 1..16 stream with `out_ready=0` from the first output for 3 cycles → `out_data=6` is held, `in_ready=0` while stalled, and no input is lost. The final sequence is still 6, 8, 14, 16.
- **Odd dimensions:** H=5, W=5, inputs 1..25 → outputs 7, 9, 17, 19. `out_last` is on 19. Inputs 20..25 are accepted with no output. The next frame starts cleanly.
- **Reset mid-frame:** H=4, W=4; assert `global_rst` for 1 cycle after 7 pixels, then send 1..16 → `out_valid=0` during and after reset until the new frame. Outputs are exactly 6, 8, 14, 16.
- **Back-to-back frames:** two 4×4 frames with `in_valid` gaps of 1–2 cycles → eight outputs, with `out_last` on the 4th and 8th.
